// File: rtl/b_io_l3_in_serialize_b_m_axi_pkg.sv
// Shared types for the m_axi serializer read path: per-burst CTRL record and tracker state encoding.
package b_io_l3_in_serialize_b_m_axi_pkg;

    typedef struct packed {
        logic       info;
        logic [7:0] len;
    } rtrack_ctrl_t;

    localparam logic RTRACK_IDLE = 1'b0;
    localparam logic RTRACK_BEAT = 1'b1;

    typedef enum logic {
        ST_IDLE = RTRACK_IDLE,
        ST_BEAT = RTRACK_BEAT
    } rtrack_state_t;

    function automatic logic is_last_beat(input logic [7:0] cnt);
        return (cnt == 8'd0);
    endfunction

endpackage

// File: rtl/b_io_l3_in_serialize_b_m_axi_rtrack_fifo.sv
// Synchronous FIFO of CTRL records; exposes the head entry and the LEN of the entry behind it.
module b_io_l3_in_serialize_b_m_axi_rtrack_fifo
    import b_io_l3_in_serialize_b_m_axi_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         push,
    input  rtrack_ctrl_t din,
    input  logic         pop,
    output rtrack_ctrl_t head,
    output logic [7:0]   next_len,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    rtrack_ctrl_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = clk_en & push & ~full;
    assign do_pop_s  = clk_en & pop & ~empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign head      = mem[rd_ptr_r];
    assign next_len  = mem[rd_ptr_r + AW'(1)].len;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/b_io_l3_in_serialize_b_m_axi_read_tracker.sv
// Read-path R-beat tracker: queues per-burst CTRL records and frames AXI R beats against them.
// Macro B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN adds a sticky RLAST mismatch flag (out_LAST_ERR).
module b_io_l3_in_serialize_b_m_axi_read_tracker
    import b_io_l3_in_serialize_b_m_axi_pkg::*;
#(
    parameter  int DATA_WIDTH      = 32,
    parameter  int NUM_OUTSTANDING = 16,
    localparam int CW              = $clog2(NUM_OUTSTANDING) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  in_CTRL_INFO,
    input  logic [7:0]            in_CTRL_LEN,
    input  logic                  in_CTRL_VALID,
    output logic                  out_CTRL_READY,
    input  logic [DATA_WIDTH-1:0] in_RDATA,
    input  logic                  in_RLAST,
    input  logic                  in_RVALID,
    output logic                  out_RREADY,
    output logic [DATA_WIDTH-1:0] out_DATA,
    output logic                  out_DATA_LAST,
    output logic                  out_DATA_VALID,
    input  logic                  in_DATA_READY,
    output logic                  out_REQ_DONE,
`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
    output logic                  out_LAST_ERR,
`endif
    output logic [CW-1:0]         out_OST_CNT
);

    rtrack_state_t state_r;
    rtrack_state_t state_nxt_s;
    logic [7:0]    beat_cnt_r;
    logic [7:0]    cnt_nxt_s;
    rtrack_ctrl_t  ctrl_in_s;
    rtrack_ctrl_t  head_s;
    logic [7:0]    next_len_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          push_s;
    logic          pop_s;
    logic          r_hs_s;
    logic          last_beat_s;

    assign ctrl_in_s   = '{info: in_CTRL_INFO, len: in_CTRL_LEN};
    assign last_beat_s = is_last_beat(beat_cnt_r);

    // Ready outputs are combinational; both drop while reset is asserted.
    assign out_CTRL_READY = clk_en & reset & ~fifo_full_s;
    assign out_RREADY     = clk_en & reset & (state_r == ST_BEAT) & (~out_DATA_VALID | in_DATA_READY);

    assign push_s = in_CTRL_VALID & out_CTRL_READY;
    assign r_hs_s = in_RVALID & out_RREADY;
    assign pop_s  = r_hs_s & last_beat_s;
    assign out_OST_CNT = fifo_count_s;

    b_io_l3_in_serialize_b_m_axi_rtrack_fifo #(
        .DEPTH (NUM_OUTSTANDING)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .push     (push_s),
        .din      (ctrl_in_s),
        .pop      (pop_s),
        .head     (head_s),
        .next_len (next_len_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    // Tracker next-state and beat counter; a second queued burst reloads without a bubble.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_BEAT;
                    cnt_nxt_s   = head_s.len;
                end else begin
                    cnt_nxt_s   = 8'd0;
                end
            end
            ST_BEAT: begin
                if (r_hs_s) begin
                    if (last_beat_s) begin
                        if (fifo_count_s > CW'(1)) begin
                            cnt_nxt_s   = next_len_s;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = 8'd0;
                        end
                    end else begin
                        cnt_nxt_s = beat_cnt_r - 8'd1;
                    end
                end else begin
                    cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Tracker state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= 8'd0;
        end else if (clk_en) begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= cnt_nxt_s;
        end
    end

    // User-side output register; holds while the user stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_DATA       <= '0;
            out_DATA_LAST  <= 1'b0;
            out_DATA_VALID <= 1'b0;
            out_REQ_DONE   <= 1'b0;
        end else if (clk_en) begin
            out_REQ_DONE <= out_DATA_VALID & out_DATA_LAST & in_DATA_READY;
            if (r_hs_s) begin
                out_DATA       <= in_RDATA;
                out_DATA_LAST  <= head_s.info & last_beat_s;
                out_DATA_VALID <= 1'b1;
            end else if (in_DATA_READY) begin
                out_DATA_VALID <= 1'b0;
            end
        end
    end

`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
    // Sticky flag: RLAST disagreed with the beat count on some handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_LAST_ERR <= 1'b0;
        end else if (clk_en && r_hs_s && (in_RLAST != last_beat_s)) begin
            out_LAST_ERR <= 1'b1;
        end
    end
`else
    logic unused_rlast_s;
    assign unused_rlast_s = in_RLAST;
`endif

endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_read_tracker.sv
// Scoreboard bench for the read tracker: directed bursts queue expected beats, a monitor checks them.
module tb_b_io_l3_in_serialize_b_m_axi_read_tracker;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clk_en = 1'b1;
    logic          in_CTRL_INFO = 1'b0;
    logic [7:0]    in_CTRL_LEN = 8'd0;
    logic          in_CTRL_VALID = 1'b0;
    logic          out_CTRL_READY;
    logic [DW-1:0] in_RDATA = '0;
    logic          in_RLAST = 1'b0;
    logic          in_RVALID = 1'b0;
    logic          out_RREADY;
    logic [DW-1:0] out_DATA;
    logic          out_DATA_LAST;
    logic          out_DATA_VALID;
    logic          in_DATA_READY = 1'b1;
    logic          out_REQ_DONE;
    logic [CW-1:0] out_OST_CNT;
`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
    logic          out_LAST_ERR;
`endif

    b_io_l3_in_serialize_b_m_axi_read_tracker #(
        .DATA_WIDTH      (DW),
        .NUM_OUTSTANDING (N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .in_CTRL_INFO   (in_CTRL_INFO),
        .in_CTRL_LEN    (in_CTRL_LEN),
        .in_CTRL_VALID  (in_CTRL_VALID),
        .out_CTRL_READY (out_CTRL_READY),
        .in_RDATA       (in_RDATA),
        .in_RLAST       (in_RLAST),
        .in_RVALID      (in_RVALID),
        .out_RREADY     (out_RREADY),
        .out_DATA       (out_DATA),
        .out_DATA_LAST  (out_DATA_LAST),
        .out_DATA_VALID (out_DATA_VALID),
        .in_DATA_READY  (in_DATA_READY),
        .out_REQ_DONE   (out_REQ_DONE),
`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
        .out_LAST_ERR   (out_LAST_ERR),
`endif
        .out_OST_CNT    (out_OST_CNT)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [DW:0]  exp_q[$];
    logic [DW-1:0] bd_q[$];
    logic         bl_q[$];
    logic         done_pending = 1'b0;
    bit           trk_en = 1'b0;
    logic [CW-1:0] ost_prev = '0;
    logic [CW-1:0] ost_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expected beat on every user handshake, checks REQ_DONE timing.
    initial begin : monitor
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                done_pending = 1'b0;
            end else begin
                checks++;
                if (out_REQ_DONE !== done_pending) begin
                    errors++;
                    $display("FAIL req_done: got %0b expected %0b", out_REQ_DONE, done_pending);
                end
                done_pending = 1'b0;
                if (out_DATA_VALID === 1'b1 && in_DATA_READY) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h last %0b expected none", out_DATA, out_DATA_LAST);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_DATA_LAST, out_DATA} !== e) begin
                            errors++;
                            $display("FAIL beat: got last %0b data %0h expected last %0b data %0h",
                                     out_DATA_LAST, out_DATA, e[DW], e[DW-1:0]);
                        end
                        done_pending = e[DW];
                    end
                end
            end
        end
    end

    // Records each change of occupancy while enabled.
    initial begin : ost_tracker
        forever begin
            @(negedge clk);
            if (trk_en && out_OST_CNT != ost_prev) begin
                ost_log.push_back(out_OST_CNT);
                ost_prev = out_OST_CNT;
            end
        end
    end

    task automatic add_beat(input logic [DW-1:0] d, input logic rlast, input logic exp_last);
        bd_q.push_back(d);
        bl_q.push_back(rlast);
        exp_q.push_back({exp_last, d});
    endtask

    task automatic push_ctrl(input logic info, input logic [7:0] len);
        int  guard = 0;
        bit  taken = 1'b0;
        in_CTRL_VALID = 1'b1;
        in_CTRL_INFO  = info;
        in_CTRL_LEN   = len;
        while (!taken && guard < 100) begin
            @(negedge clk);
            taken = out_CTRL_READY;
            @(posedge clk);
            #1;
            guard++;
        end
        in_CTRL_VALID = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL ctrl_push_timeout: got no ready expected ready");
        end
    endtask

    // Drives bd_q/bl_q as R beats; counts RREADY stalls after the first handshake.
    task automatic send_beats(output int stalls);
        int idx = 0;
        int guard = 0;
        bit started = 1'b0;
        stalls = 0;
        while (idx < bd_q.size() && guard < 2000) begin
            in_RVALID = 1'b1;
            in_RDATA  = bd_q[idx];
            in_RLAST  = bl_q[idx];
            @(negedge clk);
            if (out_RREADY) begin
                idx++;
                started = 1'b1;
            end else if (started) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_RVALID = 1'b0;
        in_RLAST  = 1'b0;
        if (idx < bd_q.size()) begin
            checks++;
            errors++;
            $display("FAIL r_timeout: got %0d beats expected %0d", idx, bd_q.size());
        end
        bd_q.delete();
        bl_q.delete();
    endtask

    task automatic user_stall();
        int g = 0;
        @(negedge clk);
        while (out_DATA_VALID !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_DATA_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rready", {63'd0, out_RREADY}, 64'd0);
            check("stall_hold", {30'd0, out_DATA_VALID, out_DATA_LAST, out_DATA},
                  {30'd0, 1'b1, 1'b0, 32'h0000_0041});
        end
        @(posedge clk);
        #1;
        in_DATA_READY = 1'b1;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : stimulus
        int st;
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {58'd0, out_DATA_VALID, out_DATA_LAST, out_REQ_DONE, out_RREADY, out_CTRL_READY, 1'b0},
              64'd0);
        check("rst_data", 64'(out_DATA), 64'd0);
        check("rst_ost", 64'(out_OST_CNT), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: single 4-beat request, continuous.
        push_ctrl(1'b1, 8'd3);
        for (int i = 0; i < 4; i++) add_beat(32'hA0 + 32'(i), (i == 3), (i == 3));
        send_beats(st);
        check("t1_stalls", 64'(st), 64'd0);
        wait_drain();

        // clk_en low freezes and masks ready.
        clk_en        = 1'b0;
        in_CTRL_VALID = 1'b1;
        in_CTRL_INFO  = 1'b1;
        in_CTRL_LEN   = 8'd0;
        repeat (2) begin
            @(negedge clk);
            check("clken_ready", {63'd0, out_CTRL_READY}, 64'd0);
            @(posedge clk);
            #1;
        end
        in_CTRL_VALID = 1'b0;
        clk_en        = 1'b1;
        @(negedge clk);
        check("clken_ost", 64'(out_OST_CNT), 64'd0);
        @(posedge clk);
        #1;

        // 2: back-to-back bursts, 16 + 2 beats, no bubble.
        push_ctrl(1'b0, 8'd15);
        push_ctrl(1'b1, 8'd1);
        @(negedge clk);
        check("t2_ost2", 64'(out_OST_CNT), 64'd2);
        ost_prev = 5'd2;
        ost_log.delete();
        trk_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) add_beat(32'h200 + 32'(i), (i == 15 || i == 17), (i == 17));
        send_beats(st);
        check("t2_stalls", 64'(st), 64'd0);
        wait_drain();
        trk_en = 1'b0;
        check("t2_ost_steps", 64'(ost_log.size()), 64'd2);
        if (ost_log.size() == 2) begin
            check("t2_ost_seq", {54'd0, ost_log[0], ost_log[1]}, {54'd0, 5'd1, 5'd0});
        end

        // 3: fill the FIFO, then one completion reopens it.
        for (int i = 0; i < N; i++) push_ctrl(1'b1, 8'd0);
        @(negedge clk);
        check("t3_full_ready", {63'd0, out_CTRL_READY}, 64'd0);
        check("t3_full_ost", 64'(out_OST_CNT), 64'd16);
        @(posedge clk);
        #1;
        add_beat(32'h300, 1'b1, 1'b1);
        send_beats(st);
        @(negedge clk);
        check("t3_ready_back", {63'd0, out_CTRL_READY}, 64'd1);
        check("t3_ost15", 64'(out_OST_CNT), 64'd15);
        @(posedge clk);
        #1;
        for (int i = 1; i < N; i++) add_beat(32'h300 + 32'(i), 1'b1, 1'b1);
        send_beats(st);
        wait_drain();

        // 4: user stall mid-burst.
        push_ctrl(1'b1, 8'd7);
        for (int i = 0; i < 8; i++) add_beat(32'h40 + 32'(i), (i == 7), (i == 7));
        fork
            send_beats(st);
            user_stall();
        join
        wait_drain();

        // 5: reset mid-burst with two entries queued.
        push_ctrl(1'b0, 8'd3);
        push_ctrl(1'b1, 8'd1);
        add_beat(32'h500, 1'b0, 1'b0);
        add_beat(32'h501, 1'b0, 1'b0);
        send_beats(st);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_flags", {59'd0, out_DATA_VALID, out_DATA_LAST, out_REQ_DONE, out_RREADY, out_CTRL_READY},
              64'd0);
        check("t5_rst_data", 64'(out_DATA), 64'd0);
        check("t5_rst_ost", 64'(out_OST_CNT), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_ctrl(1'b1, 8'd0);
        add_beat(32'h55, 1'b1, 1'b1);
        send_beats(st);
        wait_drain();
        check("t5_ost_after", 64'(out_OST_CNT), 64'd0);

        // 6: early RLAST; data flow unaffected, flag sticky when present.
`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
        check("t6_err_clear", {63'd0, out_LAST_ERR}, 64'd0);
`endif
        push_ctrl(1'b1, 8'd2);
        add_beat(32'h60, 1'b0, 1'b0);
        add_beat(32'h61, 1'b1, 1'b0);
        add_beat(32'h62, 1'b0, 1'b1);
        send_beats(st);
        wait_drain();
`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
        check("t6_err_set", {63'd0, out_LAST_ERR}, 64'd1);
`endif
        push_ctrl(1'b1, 8'd0);
        add_beat(32'h70, 1'b1, 1'b1);
        send_beats(st);
        wait_drain();
`ifdef B_IO_L3_IN_SERIALIZE_B_RTRACK_LAST_CHECK_EN
        check("t6_err_sticky", {63'd0, out_LAST_ERR}, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
